// File: rtl/fight_pkg.sv
`default_nettype none
// ============================================================================
// fight_pkg : shared attack-phase state, game mode and hit-geometry defaults
// Revision  : 1.0
// ============================================================================
package fight_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } atk_state_t;

    localparam logic [2:0] GM_FIGHT = 3'b010;

    // Shared by both the player 1 and the mirrored player 2 resolver.
    localparam int c_DEFAULT_PUNCH_REACH    = 40;
    localparam int c_DEFAULT_KICK_REACH     = 55;
    localparam int c_DEFAULT_Y_TOL          = 30;
    localparam int c_DEFAULT_WINDUP_FRAMES  = 3;
    localparam int c_DEFAULT_ACTIVE_FRAMES  = 4;
    localparam int c_DEFAULT_RECOVER_FRAMES = 8;

endpackage
`default_nettype wire

// File: rtl/abs_diff10.sv
`default_nettype none
// ============================================================================
// abs_diff10 : combinational |a - b| of two unsigned 10-bit pixel coordinates
// Revision   : 1.0
// ============================================================================
module abs_diff10 (
    input  logic [9:0] i_a,
    input  logic [9:0] i_b,
    output logic [9:0] o_diff
);

    logic signed [10:0] w_a;
    logic signed [10:0] w_b;
    logic signed [10:0] w_d;
    logic signed [10:0] w_neg;

    // Coordinates are unsigned pixels, so the 11-bit extension is zero-filled.
    assign w_a    = $signed({1'b0, i_a});
    assign w_b    = $signed({1'b0, i_b});
    assign w_d    = w_a - w_b;
    assign w_neg  = -w_d;
    assign o_diff = w_d[10] ? w_neg[9:0] : w_d[9:0];

endmodule
`default_nettype wire

// File: rtl/p1_hit_detect.sv
`default_nettype none
// ============================================================================
// p1_hit_detect : resolves player 2 punches/kicks into one-frame p_hit pulses
// Revision      : 1.0
// ============================================================================
module p1_hit_detect
    import fight_pkg::*;
#(
    parameter int PUNCH_REACH    = c_DEFAULT_PUNCH_REACH,
    parameter int KICK_REACH     = c_DEFAULT_KICK_REACH,
    parameter int Y_TOL          = c_DEFAULT_Y_TOL,
    parameter int WINDUP_FRAMES  = c_DEFAULT_WINDUP_FRAMES,
    parameter int ACTIVE_FRAMES  = c_DEFAULT_ACTIVE_FRAMES,
    parameter int RECOVER_FRAMES = c_DEFAULT_RECOVER_FRAMES
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       atk_punch,
    input  logic       atk_kick,
    input  logic [9:0] atk_posx,
    input  logic [9:0] atk_posy,
    input  logic [9:0] def_posx,
    input  logic [9:0] def_posy,
    input  logic       def_block,
    input  logic       def_lose,
    input  logic [2:0] game_mode,
    output logic       p_hit,
    output logic       atk_busy,
    output logic       atk_kind,
    output logic [7:0] hit_count
);

    localparam logic [9:0] c_PUNCH_REACH  = 10'(PUNCH_REACH);
    localparam logic [9:0] c_KICK_REACH   = 10'(KICK_REACH);
    localparam logic [9:0] c_Y_TOL        = 10'(Y_TOL);
    localparam logic [7:0] c_WINDUP_LAST  = 8'(WINDUP_FRAMES - 1);
    localparam logic [7:0] c_ACTIVE_LAST  = 8'(ACTIVE_FRAMES - 1);
    localparam logic [7:0] c_RECOVER_LAST = 8'(RECOVER_FRAMES - 1);

    atk_state_t r_state;
    logic [7:0] r_cnt;
    logic       r_p_hit;
    logic       r_atk_kind;
    logic [7:0] r_hit_count;
    logic       r_punch_q;
    logic       r_kick_q;
    logic       r_hit_done;

    logic [9:0] w_abs_dx;
    logic [9:0] w_abs_dy;
    logic [9:0] w_reach;
    logic       w_punch_rise;
    logic       w_kick_rise;
    logic       w_land;
    logic       w_abort;

    abs_diff10 u_abs_x (.i_a(atk_posx), .i_b(def_posx), .o_diff(w_abs_dx));
    abs_diff10 u_abs_y (.i_a(atk_posy), .i_b(def_posy), .o_diff(w_abs_dy));

    assign w_punch_rise = atk_punch & ~r_punch_q;
    assign w_kick_rise  = atk_kick  & ~r_kick_q;
    assign w_reach      = r_atk_kind ? c_KICK_REACH : c_PUNCH_REACH;
    assign w_land       = (w_abs_dx <= w_reach) & (w_abs_dy <= c_Y_TOL)
                        & ~def_block & ~r_hit_done;
    assign w_abort      = (game_mode != GM_FIGHT) | def_lose;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_p_hit     <= 1'b0;
            r_atk_kind  <= 1'b0;
            r_hit_count <= 8'd0;
            r_punch_q   <= 1'b0;
            r_kick_q    <= 1'b0;
            r_hit_done  <= 1'b0;
        end else begin
            // Button history always tracks, so a press held through an attack never retriggers.
            r_punch_q <= atk_punch;
            r_kick_q  <= atk_kick;
            r_p_hit   <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
                r_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_punch_rise | w_kick_rise) begin
                            r_state    <= WINDUP;
                            r_cnt      <= c_WINDUP_LAST;
                            r_hit_done <= 1'b0;
                            r_atk_kind <= w_kick_rise;
                        end
                    end
                    WINDUP: begin
                        if (r_cnt == 8'd0) begin
                            r_state <= ACTIVE;
                            r_cnt   <= c_ACTIVE_LAST;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    ACTIVE: begin
                        if (w_land) begin
                            r_p_hit    <= 1'b1;
                            r_hit_done <= 1'b1;
                            if (r_hit_count != 8'hFF) begin
                                r_hit_count <= r_hit_count + 8'd1;
                            end
                        end
                        if (r_cnt == 8'd0) begin
                            r_state <= RECOVER;
                            r_cnt   <= c_RECOVER_LAST;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    RECOVER: begin
                        if (r_cnt == 8'd0) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign p_hit     = r_p_hit;
    assign atk_busy  = (r_state != IDLE);
    assign atk_kind  = r_atk_kind;
    assign hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_p1_hit_detect.sv
`default_nettype none
// ============================================================================
// tb_p1_hit_detect : directed scoreboard bench for p1_hit_detect
// Revision         : 1.0
// ============================================================================
module tb_p1_hit_detect;
    import fight_pkg::*;

    logic       frame_clk = 1'b0;
    logic       Reset     = 1'b1;
    logic       atk_punch = 1'b0;
    logic       atk_kick  = 1'b0;
    logic [9:0] atk_posx  = 10'd100;
    logic [9:0] atk_posy  = 10'd200;
    logic [9:0] def_posx  = 10'd130;
    logic [9:0] def_posy  = 10'd200;
    logic       def_block = 1'b0;
    logic       def_lose  = 1'b0;
    logic [2:0] game_mode = GM_FIGHT;
    logic       p_hit;
    logic       atk_busy;
    logic       atk_kind;
    logic [7:0] hit_count;

    p1_hit_detect dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .atk_punch (atk_punch),
        .atk_kick  (atk_kick),
        .atk_posx  (atk_posx),
        .atk_posy  (atk_posy),
        .def_posx  (def_posx),
        .def_posy  (def_posy),
        .def_block (def_block),
        .def_lose  (def_lose),
        .game_mode (game_mode),
        .p_hit     (p_hit),
        .atk_busy  (atk_busy),
        .atk_kind  (atk_kind),
        .hit_count (hit_count)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%0d expected=entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One quiet frame: no buttons, block clear, nothing in flight.
    task automatic idle_frame();
        atk_punch = 1'b0;
        atk_kick  = 1'b0;
        def_block = 1'b0;
        def_lose  = 1'b0;
        push_exp("idle_p_hit", 8'd0);
        push_exp("idle_atk_busy", 8'd0);
        @(posedge frame_clk);
        @(negedge frame_clk);
        pop_chk({7'd0, p_hit});
        pop_chk({7'd0, atk_busy});
    endtask

    // One attack; frame f is the result after the f-th edge from the first press.
    task automatic attack(input logic pb, input logic kb,
                          input int ax, input int ay, input int dx, input int dy,
                          input logic [63:0] btn_mask, input logic [3:0] blk_mask,
                          input int lose_f, input int nframes);
        int   reach;
        bit   inr;
        int   hit_f;
        bit   aborted;
        atk_posx = 10'(ax);
        atk_posy = 10'(ay);
        def_posx = 10'(dx);
        def_posy = 10'(dy);
        reach = kb ? 55 : 40;
        inr   = (iabs(ax - dx) <= reach) && (iabs(ay - dy) <= 30);
        hit_f = -1;
        for (int j = 0; j < 4; j++) begin
            if (hit_f < 0 && inr && !blk_mask[j]) hit_f = 4 + j;
        end
        if (lose_f >= 0 && hit_f >= lose_f) hit_f = -1;
        for (int f = 0; f < nframes; f++) begin
            atk_punch = pb & btn_mask[f];
            atk_kick  = kb & btn_mask[f];
            def_block = (f >= 4 && f < 8) ? blk_mask[f-4] : 1'b0;
            def_lose  = (f == lose_f);
            aborted   = (lose_f >= 0) && (f >= lose_f);
            push_exp($sformatf("p_hit_f%0d", f), {7'd0, (f == hit_f)});
            push_exp($sformatf("atk_busy_f%0d", f), {7'd0, (f < 15) && !aborted});
            @(posedge frame_clk);
            @(negedge frame_clk);
            pop_chk({7'd0, p_hit});
            pop_chk({7'd0, atk_busy});
        end
        atk_punch = 1'b0;
        atk_kick  = 1'b0;
        def_block = 1'b0;
        def_lose  = 1'b0;
        if (hit_f >= 0 && exp_count < 255) exp_count++;
        chk("atk_kind", {7'd0, atk_kind}, {7'd0, kb});
        chk("hit_count", hit_count, 8'(exp_count));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge frame_clk);
        chk("rst_p_hit", {7'd0, p_hit}, 8'd0);
        chk("rst_atk_busy", {7'd0, atk_busy}, 8'd0);
        chk("rst_atk_kind", {7'd0, atk_kind}, 8'd0);
        chk("rst_hit_count", hit_count, 8'd0);
        Reset = 1'b0;
        idle_frame();

        // Punch in range, kick at 50, punch out of range at 50, simultaneous rise
        attack(1, 0, 100, 200, 130, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();
        attack(0, 1, 150, 200, 100, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();
        attack(1, 0, 100, 200, 150, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();
        attack(1, 1, 100, 200, 150, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();

        // Held 40 frames: one attack only
        attack(1, 0, 100, 200, 110, 200, (64'd1 << 40) - 64'd1, 4'b0000, -1, 41);
        idle_frame();
        // Re-press in RECOVER (f10) and on the RECOVER exit frame (f15): ignored
        attack(1, 0, 100, 200, 110, 200, 64'h1_8403, 4'b0000, -1, 18);
        idle_frame();
        attack(1, 0, 100, 200, 110, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();

        // Blocking: whole ACTIVE, then dropped on the third ACTIVE frame
        attack(1, 0, 300, 200, 280, 200, 64'h1, 4'b1111, -1, 16);
        idle_frame();
        attack(1, 0, 300, 200, 280, 200, 64'h1, 4'b0011, -1, 16);
        idle_frame();

        // Reach boundaries
        attack(1, 0, 300, 200, 340, 230, 64'h1, 4'b0000, -1, 16);
        idle_frame();
        attack(1, 0, 300, 200, 300, 231, 64'h1, 4'b0000, -1, 16);
        idle_frame();
        attack(0, 1, 400, 100, 344, 100, 64'h1, 4'b0000, -1, 16);
        idle_frame();

        // Reset during WINDUP
        atk_punch = 1'b1;
        push_exp("wu_p_hit", 8'd0);
        push_exp("wu_atk_busy", 8'd1);
        @(posedge frame_clk);
        @(negedge frame_clk);
        pop_chk({7'd0, p_hit});
        pop_chk({7'd0, atk_busy});
        atk_punch = 1'b0;
        Reset = 1'b1;
        #1;
        exp_count = 0;
        chk("arst_p_hit", {7'd0, p_hit}, 8'd0);
        chk("arst_atk_busy", {7'd0, atk_busy}, 8'd0);
        chk("arst_hit_count", hit_count, 8'd0);
        @(posedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
        repeat (3) idle_frame();
        attack(1, 0, 100, 200, 130, 200, 64'h1, 4'b0000, -1, 16);
        idle_frame();

        // def_lose on the first ACTIVE frame aborts the in-range hit
        attack(1, 0, 100, 200, 130, 200, 64'h1, 4'b0000, 4, 16);
        idle_frame();

        chk("sb_drained", 8'(sb.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
